// File: rtl/register_file_if.sv
// Register file access bundle: write-back port plus two read ports (A/B).
// Master drives indices and write data; slave returns combinational read data.
interface register_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              write_back_en;
    logic [ADDR_W-1:0] write_back_reg;
    logic [DATA_W-1:0] write_back;
    logic [ADDR_W-1:0] a_reg;
    logic [ADDR_W-1:0] b_reg;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;

    modport master (
        output write_back_en, write_back_reg, write_back, a_reg, b_reg,
        input  a, b
    );

    modport slave (
        input  write_back_en, write_back_reg, write_back, a_reg, b_reg,
        output a, b
    );
endinterface

// File: rtl/register_file.sv
// 32x32 MIPS register file: two zero-latency read ports, one write port on the rising edge.
// No backpressure; reg 0 reads as zero and optional same-cycle write forwarding to reads.
module register_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst,
    register_file_if.slave  rf
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_regs [DEPTH];

    logic w_wr_act;
    logic w_a_byp;
    logic w_b_byp;

    // A write only counts when it can actually land: out of reset and not targeting reg 0.
    assign w_wr_act = !rst && rf.write_back_en && (rf.write_back_reg != '0);
    assign w_a_byp  = (BYPASS != 0) && w_wr_act && (rf.write_back_reg == rf.a_reg);
    assign w_b_byp  = (BYPASS != 0) && w_wr_act && (rf.write_back_reg == rf.b_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_act) begin
            r_regs[rf.write_back_reg] <= rf.write_back;
        end
    end

    assign rf.a = (rf.a_reg == '0) ? '0 : (w_a_byp ? rf.write_back : r_regs[rf.a_reg]);
    assign rf.b = (rf.b_reg == '0) ? '0 : (w_b_byp ? rf.write_back : r_regs[rf.b_reg]);
endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: drives one stimulus stream into a forwarding and a non-forwarding
// instance and checks both against a simple array model plus a table of directed vectors.
module tb_register_file;
    logic        clk;
    logic        rst;
    logic        en;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [4:0]  ar;
    logic [4:0]  br;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [32];

    register_file_if #(.DATA_W(32), .ADDR_W(5)) rf1 ();
    register_file_if #(.DATA_W(32), .ADDR_W(5)) rf0 ();

    assign rf1.write_back_en  = en;
    assign rf1.write_back_reg = wr;
    assign rf1.write_back     = wd;
    assign rf1.a_reg          = ar;
    assign rf1.b_reg          = br;
    assign rf0.write_back_en  = en;
    assign rf0.write_back_reg = wr;
    assign rf0.write_back     = wd;
    assign rf0.a_reg          = ar;
    assign rf0.b_reg          = br;

    register_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) u_dut_byp (
        .clk (clk),
        .rst (rst),
        .rf  (rf1)
    );

    register_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) u_dut_nobyp (
        .clk (clk),
        .rst (rst),
        .rf  (rf0)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        logic        en;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [4:0]  ar;
        logic [4:0]  br;
        logic [31:0] a_byp;
        logic [31:0] b_byp;
        logic [31:0] a_nobyp;
        logic [31:0] b_nobyp;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_read(input logic [4:0] idx, input bit fwd);
        if (idx == 5'd0 || rst) return 32'h0;
        if (fwd && en && wr != 5'd0 && wr == idx) return wd;
        return model[idx];
    endfunction

    task automatic check_both(input string nm);
        chk({nm, " a byp"},   rf1.a, ref_read(ar, 1'b1));
        chk({nm, " b byp"},   rf1.b, ref_read(br, 1'b1));
        chk({nm, " a nobyp"}, rf0.a, ref_read(ar, 1'b0));
        chk({nm, " b nobyp"}, rf0.b, ref_read(br, 1'b0));
    endtask

    // Advance one clock, applying the architectural write rule to the model.
    task automatic tick();
        @(posedge clk);
        if (!rst && en && wr != 5'd0) model[wr] = wd;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        wr  = '0;
        wd  = '0;
        ar  = '0;
        br  = '0;
        foreach (model[i]) model[i] = 32'h0;

        vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        32'h0};
        vecs[1] = '{1'b0, 5'd7, 32'h00001234, 5'd5, 5'd7, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0};
        vecs[2] = '{1'b1, 5'd7, 32'h00001234, 5'd7, 5'd0, 32'h00001234, 32'h0,        32'h0,        32'h0};
        vecs[3] = '{1'b0, 5'd7, 32'h0000AAAA, 5'd7, 5'd5, 32'h00001234, 32'hDEADBEEF, 32'h00001234, 32'hDEADBEEF};
        vecs[4] = '{1'b0, 5'd7, 32'h00005555, 5'd7, 5'd7, 32'h00001234, 32'h00001234, 32'h00001234, 32'h00001234};
        vecs[5] = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 32'h0,        32'h0,        32'h0,        32'h0};
        vecs[6] = '{1'b0, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd7, 32'h0,        32'h00001234, 32'h0,        32'h00001234};
        vecs[7] = '{1'b1, 5'd5, 32'h00000000, 5'd5, 5'd5, 32'h0,        32'h0,        32'hDEADBEEF, 32'hDEADBEEF};
        vecs[8] = '{1'b0, 5'd5, 32'h00000000, 5'd5, 5'd5, 32'h0,        32'h0,        32'h0,        32'h0};

        // Reset read-back, with write attempts that must be ignored while held in reset.
        #1;
        for (int k = 0; k < 32; k++) begin
            en = 1'b1;
            wr = 5'(k);
            wd = $urandom;
            ar = 5'(k);
            br = 5'(31 - k);
            #2;
            chk($sformatf("reset a[%0d] byp", k), rf1.a, 32'h0);
            chk($sformatf("reset b[%0d] byp", 31 - k), rf1.b, 32'h0);
            chk($sformatf("reset a[%0d] nobyp", k), rf0.a, 32'h0);
            tick();
        end
        en  = 1'b0;
        rst = 1'b0;
        tick();

        // Directed table: expectations are sampled before the edge of each vector's cycle.
        for (int v = 0; v < 9; v++) begin
            en = vecs[v].en;
            wr = vecs[v].wr;
            wd = vecs[v].wd;
            ar = vecs[v].ar;
            br = vecs[v].br;
            #2;
            chk($sformatf("vec%0d a byp", v),   rf1.a, vecs[v].a_byp);
            chk($sformatf("vec%0d b byp", v),   rf1.b, vecs[v].b_byp);
            chk($sformatf("vec%0d a nobyp", v), rf0.a, vecs[v].a_nobyp);
            chk($sformatf("vec%0d b nobyp", v), rf0.b, vecs[v].b_nobyp);
            tick();
        end

        // Write sweep k -> reg k, then read every index back on both ports.
        for (int k = 0; k < 32; k++) begin
            en = 1'b1;
            wr = 5'(k);
            wd = 32'(k);
            tick();
        end
        en = 1'b0;
        for (int k = 0; k < 32; k++) begin
            ar = 5'(k);
            br = 5'((k + 1) % 32);
            #2;
            chk($sformatf("sweep a[%0d]", k), rf1.a, (k == 0) ? 32'h0 : 32'(k));
            chk($sformatf("sweep a[%0d] nobyp", k), rf0.a, (k == 0) ? 32'h0 : 32'(k));
            chk($sformatf("sweep b[%0d]", (k + 1) % 32), rf1.b, ((k + 1) % 32 == 0) ? 32'h0 : 32'((k + 1) % 32));
            tick();
        end

        // Asynchronous reset asserted and released between clock edges.
        ar = 5'd3;
        br = 5'd31;
        #4;
        rst = 1'b1;
        #1;
        chk("async rst a", rf1.a, 32'h0);
        chk("async rst b", rf1.b, 32'h0);
        chk("async rst a nobyp", rf0.a, 32'h0);
        en = 1'b1;
        wr = 5'd9;
        wd = 32'hCAFEF00D;
        ar = 5'd9;
        #1;
        chk("rst blocks bypass", rf1.a, 32'h0);
        en = 1'b0;
        #1;
        rst = 1'b0;
        foreach (model[i]) model[i] = 32'h0;
        tick();
        for (int k = 0; k < 32; k += 2) begin
            ar = 5'(k);
            br = 5'(k + 1);
            #2;
            chk($sformatf("post-rst a[%0d]", k), rf1.a, 32'h0);
            chk($sformatf("post-rst b[%0d]", k + 1), rf0.b, 32'h0);
            tick();
        end
        en = 1'b1;
        wr = 5'd4;
        wd = 32'h00000044;
        tick();
        en = 1'b0;
        ar = 5'd4;
        #2;
        chk("write after rst", rf0.a, 32'h00000044);
        tick();

        // Randomized traffic against the array model; biased toward index collisions.
        for (int n = 0; n < 400; n++) begin
            en = ($urandom_range(0, 3) != 0);
            wr = 5'($urandom_range(0, 31));
            wd = $urandom;
            ar = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
            br = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
            if ($urandom_range(0, 15) == 0) wr = 5'd0;
            #2;
            check_both($sformatf("rand%0d", n));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
